// File: rtl/multicycle.sv
// Multicycle 8-bit CPU (FETCH/DECODE/EXEC/MEM/HALT) with seven-segment debug displays.
// Optional MULTICYCLE_CYCLE_COUNT_EN adds a saturating 16-bit cycle counter shown when SW[2]=1.
`timescale 1ns/1ps
module multicycle #(
  parameter string MemFile = "data.hex"
) (
  input  logic [2:0]  SW,
  input  logic [1:0]  KEY,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [7:0]  LEDG,
  output logic [17:0] LEDR
);
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StHalt   = 3'd4
  } state_e;

  logic clk, rst_n;
  assign clk   = KEY[1];
  assign rst_n = KEY[0];

  state_e     state_q;
  logic [7:0] pc_q, ir_q, a_q, b_q;
  logic [7:0] regs_q [4];
  logic       z_q, n_q;
  logic [7:0] mem [256];

  logic [3:0] op;
  logic       is_load, is_store, is_stop, is_ori, is_shift;
  logic       alu_wr, br_taken;
  logic [1:0] alu_dst;
  logic [7:0] alu_res;
  logic [7:0] br_off;

  assign op     = ir_q[3:0];
  assign br_off = {{4{ir_q[7]}}, ir_q[7:4]};

  always_comb begin
    is_ori   = (ir_q[2:0] == 3'b111);
    is_shift = (ir_q[2:0] == 3'b011);
    is_load  = (op == 4'b0000);
    is_store = (op == 4'b0010);
    is_stop  = (op == 4'b0001);
    alu_wr   = 1'b1;
    alu_dst  = ir_q[7:6];
    alu_res  = '0;
    br_taken = 1'b0;
    if (is_ori) begin
      alu_res = regs_q[1] | {3'b000, ir_q[7:3]};
      alu_dst = 2'd1;
    end else if (is_shift) begin
      alu_res = ir_q[5] ? (a_q << ir_q[4:3]) : (a_q >> ir_q[4:3]);
    end else begin
      alu_wr = 1'b0;
      // Anything not listed here (including undefined opcodes) behaves as nop.
      case (op)
        4'b0100: begin alu_res = a_q + b_q;    alu_wr = 1'b1; end
        4'b0110: begin alu_res = a_q - b_q;    alu_wr = 1'b1; end
        4'b1000: begin alu_res = ~(a_q & b_q); alu_wr = 1'b1; end
        4'b0101: br_taken = z_q;
        4'b1001: br_taken = ~z_q;
        4'b1101: br_taken = ~n_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          ir_q    <= mem[pc_q];
          pc_q    <= pc_q + 8'd1;
          state_q <= StDecode;
        end
        StDecode: begin
          a_q     <= regs_q[ir_q[7:6]];
          b_q     <= regs_q[ir_q[5:4]];
          state_q <= StExec;
        end
        StExec: begin
          state_q <= StFetch;
          if (alu_wr) begin
            regs_q[alu_dst] <= alu_res;
            z_q             <= (alu_res == 8'h00);
            n_q             <= alu_res[7];
          end
          if (br_taken) pc_q <= pc_q + br_off;
          if (is_load || is_store) state_q <= StMem;
          if (is_stop) state_q <= StHalt;
        end
        StMem: begin
          if (is_load) regs_q[ir_q[7:6]] <= mem[b_q];
          state_q <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == StMem && is_store) mem[b_q] <= a_q;
  end

  logic show_cyc;
  logic [15:0] cyc_val;
`ifdef MULTICYCLE_CYCLE_COUNT_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (state_q != StHalt && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end
  assign show_cyc = SW[2];
  assign cyc_val  = cyc_q;
`else
  logic unused_sw2;
  assign unused_sw2 = SW[2];
  assign show_cyc   = 1'b0;
  assign cyc_val    = '0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [31:0] disp;
  logic        blank_hi;

  always_comb begin
    disp     = {mem[pc_q], ir_q, pc_q, regs_q[SW[1:0]]};
    blank_hi = 1'b0;
    if (show_cyc) begin
      disp[15:0] = cyc_val;
      blank_hi   = 1'b1;
    end
  end

  assign HEX0 = seg7(disp[3:0]);
  assign HEX1 = seg7(disp[7:4]);
  assign HEX2 = seg7(disp[11:8]);
  assign HEX3 = seg7(disp[15:12]);
  assign HEX4 = blank_hi ? 7'h7F : seg7(disp[19:16]);
  assign HEX5 = blank_hi ? 7'h7F : seg7(disp[23:20]);
  assign HEX6 = blank_hi ? 7'h7F : seg7(disp[27:24]);
  assign HEX7 = blank_hi ? 7'h7F : seg7(disp[31:28]);

  assign LEDG = {5'b00000, n_q, z_q, (state_q == StHalt)};
  assign LEDR = {15'h0000, state_q};

endmodule

// File: tb/tb_multicycle.sv
// Bench for multicycle: directed programs and random programs checked against an
// instruction-level reference model through the displays and LEDs.
`timescale 1ns/1ps
module tb_multicycle;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sw = 3'b000;
  logic [1:0]  key;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [7:0]  ledg;
  logic [17:0] ledr;

  assign key = {clk, rst_n};

  multicycle #(.MemFile("")) dut (
    .SW(sw), .KEY(key),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .HEX4(hex4), .HEX5(hex5), .HEX6(hex6), .HEX7(hex7),
    .LEDG(ledg), .LEDR(ledr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state only, advanced one instruction at a time.
  logic [7:0] m_mem [256];
  logic [7:0] m_r [4];
  logic [7:0] m_pc, m_ir;
  logic       m_z, m_n, m_halt;
  int         m_cyc;

  logic [7:0]  o_r [4];
  logic [7:0]  o_pc;
  logic        o_halt;
  logic [15:0] o_cnt;
  logic [8:0]  ld_idx;

  function automatic logic [3:0] unseg(input logic [6:0] s);
    case (s)
      7'h40: return 4'h0;
      7'h79: return 4'h1;
      7'h24: return 4'h2;
      7'h30: return 4'h3;
      7'h19: return 4'h4;
      7'h12: return 4'h5;
      7'h02: return 4'h6;
      7'h78: return 4'h7;
      7'h00: return 4'h8;
      7'h10: return 4'h9;
      7'h08: return 4'hA;
      7'h03: return 4'hB;
      7'h46: return 4'hC;
      7'h21: return 4'hD;
      7'h06: return 4'hE;
      7'h0E: return 4'hF;
      default: return 4'bxxxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_ir = 8'h00; m_z = 1'b0; m_n = 1'b0; m_halt = 1'b0; m_cyc = 0;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
  endtask

  task automatic m_step(output int cyc);
    logic [7:0] ins, x, y, res;
    int rx, ry, sh, sx;
    logic upd, br;
    cyc = 1;
    if (m_halt) return;
    ins = m_mem[m_pc];
    m_ir = ins;
    m_pc = 8'((int'(m_pc) + 1) % 256);
    rx = int'(ins[7:6]); ry = int'(ins[5:4]); sh = int'(ins[4:3]);
    x = m_r[rx]; y = m_r[ry];
    sx = int'(ins[7:4]); if (sx > 7) sx = sx - 16;
    upd = 1'b0; br = 1'b0; res = 8'h00; cyc = 3;
    if (ins[2:0] == 3'b111) begin
      res = m_r[1] | (ins >> 3); rx = 1; upd = 1'b1;
    end else if (ins[2:0] == 3'b011) begin
      res = ins[5] ? 8'((int'(x) * (2 ** sh)) % 256) : 8'(int'(x) / (2 ** sh));
      upd = 1'b1;
    end else begin
      case (ins[3:0])
        4'h0: begin m_r[rx] = m_mem[y]; cyc = 4; end
        4'h2: begin m_mem[y] = x; cyc = 4; end
        4'h4: begin res = 8'((int'(x) + int'(y)) % 256); upd = 1'b1; end
        4'h6: begin res = 8'((int'(x) - int'(y) + 256) % 256); upd = 1'b1; end
        4'h8: begin res = ~(x & y); upd = 1'b1; end
        4'h1: m_halt = 1'b1;
        4'h5: br = m_z;
        4'h9: br = !m_z;
        4'hD: br = !m_n;
        default: ;
      endcase
    end
    if (upd) begin
      m_r[rx] = res; m_z = (res == 8'h00); m_n = (res >= 8'h80);
    end
    if (br) m_pc = 8'((int'(m_pc) + sx + 256) % 256);
    m_cyc = (m_cyc + cyc > 65535) ? 65535 : m_cyc + cyc;
  endtask

  task load_dut();
    for (ld_idx = 9'd0; ld_idx < 9'd256; ld_idx++) dut.mem[ld_idx[7:0]] <= m_mem[ld_idx[7:0]];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 4; r++) begin
      sw = 3'(r);
      #1;
      o_r[r] = {unseg(hex1), unseg(hex0)};
      check($sformatf("%s R%0d", tag, r), 32'(o_r[r]), 32'(m_r[r]));
    end
    o_pc = {unseg(hex3), unseg(hex2)};
    check({tag, " pc"}, 32'(o_pc), 32'(m_pc));
    check({tag, " ir"}, 32'({unseg(hex5), unseg(hex4)}), 32'(m_ir));
    check({tag, " mem[pc]"}, 32'({unseg(hex7), unseg(hex6)}), 32'(m_mem[m_pc]));
    check({tag, " z"}, 32'(ledg[1]), 32'(m_z));
    check({tag, " n"}, 32'(ledg[2]), 32'(m_n));
    o_halt = ledg[0];
    check({tag, " halted"}, 32'(o_halt), 32'(m_halt));
    check({tag, " state"}, 32'(ledr[2:0]), m_halt ? 32'd4 : 32'd0);
    check({tag, " led zeros"}, {17'h0, ledr[17:3]}, 32'(ledg[7:3]));
    sw = 3'b100;
    #1;
`ifdef MULTICYCLE_CYCLE_COUNT_EN
    o_cnt = {unseg(hex3), unseg(hex2), unseg(hex1), unseg(hex0)};
    check({tag, " counter"}, 32'(o_cnt), 32'(m_cyc));
    check({tag, " blank"}, {4'h0, hex7, hex6, hex5, hex4}, {4'h0, {4{7'h7F}}});
`else
    check({tag, " sw2 ignored"}, 32'({unseg(hex3), unseg(hex2)}), 32'(m_pc));
`endif
    sw = 3'b000;
  endtask

  task automatic step(input string tag);
    int cyc;
    m_step(cyc);
    for (int c = 1; c < cyc; c++) begin
      tick();
      check($sformatf("%s state@%0d", tag, c), 32'(ledr[2:0]), 32'(c));
    end
    tick();
    check_all(tag);
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    load_dut();
    m_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // ori 5; add R1,R1; stop
    m_clear();
    m_mem[0] = 8'h2F; m_mem[1] = 8'h54; m_mem[2] = 8'h01;
    load_dut();
    m_reset();
    #1;
    check_all("A reset");
    #(41 - $time);
    rst_n = 1'b1;
    step("A ori");
    check("A ori R1", 32'(o_r[1]), 32'h05);
    check("A ori pc", 32'(o_pc), 32'h01);
    step("A add");
    check("A add R1", 32'(o_r[1]), 32'h0A);
    step("A stop");
    check("A halted", 32'(o_halt), 32'd1);
    check("A halt pc", 32'(o_pc), 32'h03);
`ifdef MULTICYCLE_CYCLE_COUNT_EN
    check("A count", 32'(o_cnt), 32'd9);
`endif
    step("A hold1");
    step("A hold2");
    check("A hold pc", 32'(o_pc), 32'h03);

    // ori 0x10; load R1,[R1]; sub R1,R1; bz -2
    m_clear();
    m_mem[0] = 8'h87; m_mem[1] = 8'h50; m_mem[2] = 8'h56; m_mem[3] = 8'hE5;
    m_mem[8'h10] = 8'h80;
    reset_dut("B reset");
    step("B ori");
    step("B load");
    check("B load R1", 32'(o_r[1]), 32'h80);
    step("B sub");
    check("B sub R1", 32'(o_r[1]), 32'h00);
    check("B sub z", 32'(ledg[1]), 32'd1);
    step("B bz");
    check("B bz pc", 32'(o_pc), 32'h02);
    step("B sub2");
    step("B bz2");

    // ori; add R0,R1; shl R1,1; store R0,[R1]; load R2,[R1]; stop
    m_clear();
    m_mem[0] = 8'h87; m_mem[1] = 8'h14; m_mem[2] = 8'h6B;
    m_mem[3] = 8'h12; m_mem[4] = 8'h90; m_mem[5] = 8'h01;
    reset_dut("C reset");
    step("C ori");
    step("C add");
    step("C shift");
    check("C shift R1", 32'(o_r[1]), 32'h20);
    step("C store");
    step("C load");
    check("C load R2", 32'(o_r[2]), 32'h10);
    step("C stop");

    // reset while add is in EXEC
    m_clear();
    m_mem[0] = 8'h87; m_mem[1] = 8'h54;
    reset_dut("D reset");
    step("D ori");
    tick();
    tick();
    check("D in exec", 32'(ledr[2:0]), 32'd2);
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("D abort");
    check("D abort R1", 32'(o_r[1]), 32'h00);
    check("D abort pc", 32'(o_pc), 32'h00);
`ifdef MULTICYCLE_CYCLE_COUNT_EN
    check("D abort count", 32'(o_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step("D ori again");
    check("D ori R1", 32'(o_r[1]), 32'h10);
    step("D add");
    check("D add R1", 32'(o_r[1]), 32'h20);

    // random programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
      reset_dut($sformatf("rnd%0d reset", p));
      for (int s = 0; s < 40 && !m_halt; s++) step($sformatf("rnd%0d step%0d", p, s));
      step($sformatf("rnd%0d last", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
